// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lsu_mem_ctrl: load/store unit, one outstanding split-handshake bus op.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RD_W           = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_mem_i,
  output logic            req_ready_o,
  input  logic            op_load_i,
  input  logic            op_store_i,
  input  logic            op_lb_i,
  input  logic            op_lh_i,
  input  logic            op_lw_i,
  input  logic            op_lbu_i,
  input  logic            op_lhu_i,
  input  logic [31:0]     addr_i,
  input  logic [3:0]      wmask_i,
  input  logic [31:0]     wdata_i,
  input  logic [RD_W-1:0] rd_i,
  input  logic            misaligned_load_i,
  input  logic            misaligned_store_i,
  input  logic            flush_i,
  output logic            bus_req_valid_o,
  input  logic            bus_req_ready_i,
  output logic            bus_req_we_o,
  output logic [31:0]     bus_req_addr_o,
  output logic [3:0]      bus_req_wmask_o,
  output logic [31:0]     bus_req_wdata_o,
  input  logic            bus_rsp_valid_i,
  output logic            bus_rsp_ready_o,
  input  logic [31:0]     bus_rsp_rdata_i,
  input  logic            bus_rsp_err_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [31:0]     wb_data_o,
  output logic            exc_valid_o,
  output logic [3:0]      exc_cause_o,
  output logic [31:0]     exc_tval_o,
  output logic            busy_o
);

  localparam int         c_CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] c_CAUSE_LMA = 4'd4;
  localparam logic [3:0] c_CAUSE_LFT = 4'd5;
  localparam logic [3:0] c_CAUSE_SMA = 4'd6;
  localparam logic [3:0] c_CAUSE_SFT = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_RESP  = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_addr, r_wdata, r_wb_data, r_exc_tval;
  logic [3:0]        r_wmask, r_exc_cause;
  logic [RD_W-1:0]   r_rd;
  logic              r_we, r_lb, r_lh, r_lbu, r_lhu, r_exc_valid;
  logic [c_CNT_W-1:0] r_cnt;

  logic              w_latch, w_cnt_clr, w_cnt_inc, w_wb_load, w_exc_set;
  logic [3:0]        w_exc_cause;
  logic [31:0]       w_exc_tval, w_fmt;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  // Lane extraction uses the latched address, since addr_i has moved on by now.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = bus_rsp_rdata_i[7:0];
      2'd1:    w_byte = bus_rsp_rdata_i[15:8];
      2'd2:    w_byte = bus_rsp_rdata_i[23:16];
      default: w_byte = bus_rsp_rdata_i[31:24];
    endcase
    w_half = r_addr[1] ? bus_rsp_rdata_i[31:16] : bus_rsp_rdata_i[15:0];
    if (r_lb)       w_fmt = {{24{w_byte[7]}}, w_byte};
    else if (r_lbu) w_fmt = {24'd0, w_byte};
    else if (r_lh)  w_fmt = {{16{w_half[15]}}, w_half};
    else if (r_lhu) w_fmt = {16'd0, w_half};
    else            w_fmt = bus_rsp_rdata_i;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_latch         = 1'b0;
    w_cnt_clr       = 1'b0;
    w_cnt_inc       = 1'b0;
    w_wb_load       = 1'b0;
    w_exc_set       = 1'b0;
    w_exc_cause     = 4'd0;
    w_exc_tval      = r_addr;
    req_ready_o     = 1'b0;
    bus_req_valid_o = 1'b0;
    bus_rsp_ready_o = 1'b0;
    wb_valid_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_mem_i && !flush_i) begin
          if (misaligned_load_i || misaligned_store_i) begin
            w_exc_set   = 1'b1;
            w_exc_cause = misaligned_load_i ? c_CAUSE_LMA : c_CAUSE_SMA;
            w_exc_tval  = addr_i;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        bus_req_valid_o = 1'b1;
        if (bus_req_ready_i) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = flush_i ? S_DRAIN : S_RESP;
        end else if (flush_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RESP: begin
        bus_rsp_ready_o = 1'b1;
        if (bus_rsp_valid_i) begin
          w_state_nxt = S_IDLE;
          if (!flush_i) begin
            if (bus_rsp_err_i) begin
              w_exc_set   = 1'b1;
              w_exc_cause = r_we ? c_CAUSE_SFT : c_CAUSE_LFT;
            end else if (!r_we) begin
              w_wb_load = 1'b1;
              if (r_rd != '0) w_state_nxt = S_WB;
            end
          end
        end else if (flush_i) begin
          w_state_nxt = S_DRAIN;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == c_TO_LAST)) begin
          // The response may still arrive; DRAIN soaks it up.
          w_exc_set   = 1'b1;
          w_exc_cause = r_we ? c_CAUSE_SFT : c_CAUSE_LFT;
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i || flush_i) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        bus_rsp_ready_o = 1'b1;
        if (bus_rsp_valid_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wmask     <= '0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_we        <= 1'b0;
      r_lb        <= 1'b0;
      r_lh        <= 1'b0;
      r_lbu       <= 1'b0;
      r_lhu       <= 1'b0;
      r_cnt       <= '0;
      r_wb_data   <= '0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= '0;
      r_exc_tval  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_exc_valid <= w_exc_set;
      if (w_latch) begin
        r_addr  <= addr_i;
        r_wmask <= op_store_i ? wmask_i : 4'd0;
        r_wdata <= wdata_i;
        r_rd    <= rd_i;
        r_we    <= op_store_i;
        r_lb    <= op_lb_i;
        r_lh    <= op_lh_i;
        r_lbu   <= op_lbu_i;
        r_lhu   <= op_lhu_i;
      end
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + c_CNT_W'(1);
      if (w_wb_load) r_wb_data <= w_fmt;
      if (w_exc_set) begin
        r_exc_cause <= w_exc_cause;
        r_exc_tval  <= w_exc_tval;
      end
    end
  end

  assign bus_req_we_o    = r_we;
  assign bus_req_addr_o  = r_addr;
  assign bus_req_wmask_o = r_wmask;
  assign bus_req_wdata_o = r_wdata;
  assign wb_rd_o         = r_rd;
  assign wb_data_o       = r_wb_data;
  assign exc_valid_o     = r_exc_valid;
  assign exc_cause_o     = r_exc_cause;
  assign exc_tval_o      = r_exc_tval;
  assign busy_o          = (r_state != S_IDLE);

  // op_lw_i is the fall-through case of the formatter and needs no latch.
  logic w_unused;
  assign w_unused = op_lw_i ^ op_load_i;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_mem_i, req_ready_o, op_load_i, op_store_i;
  logic        op_lb_i, op_lh_i, op_lw_i, op_lbu_i, op_lhu_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  wmask_i;
  logic [4:0]  rd_i;
  logic        misaligned_load_i, misaligned_store_i, flush_i;
  logic        bus_req_valid_o, bus_req_ready_i, bus_req_we_o;
  logic [31:0] bus_req_addr_o, bus_req_wdata_o;
  logic [3:0]  bus_req_wmask_o;
  logic        bus_rsp_valid_i, bus_rsp_ready_o, bus_rsp_err_i;
  logic [31:0] bus_rsp_rdata_i;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        exc_valid_o;
  logic [3:0]  exc_cause_o;
  logic [31:0] exc_tval_o;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(8), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_mem_i(req_mem_i), .req_ready_o(req_ready_o),
    .op_load_i(op_load_i), .op_store_i(op_store_i),
    .op_lb_i(op_lb_i), .op_lh_i(op_lh_i), .op_lw_i(op_lw_i),
    .op_lbu_i(op_lbu_i), .op_lhu_i(op_lhu_i),
    .addr_i(addr_i), .wmask_i(wmask_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .misaligned_load_i(misaligned_load_i), .misaligned_store_i(misaligned_store_i),
    .flush_i(flush_i),
    .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
    .bus_req_we_o(bus_req_we_o), .bus_req_addr_o(bus_req_addr_o),
    .bus_req_wmask_o(bus_req_wmask_o), .bus_req_wdata_o(bus_req_wdata_o),
    .bus_rsp_valid_i(bus_rsp_valid_i), .bus_rsp_ready_o(bus_rsp_ready_o),
    .bus_rsp_rdata_i(bus_rsp_rdata_i), .bus_rsp_err_i(bus_rsp_err_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_mem_i = 0; op_load_i = 0; op_store_i = 0;
    op_lb_i = 0; op_lh_i = 0; op_lw_i = 0; op_lbu_i = 0; op_lhu_i = 0;
    addr_i = 0; wmask_i = 0; wdata_i = 0; rd_i = 0;
    misaligned_load_i = 0; misaligned_store_i = 0; flush_i = 0;
    bus_req_ready_i = 0; bus_rsp_valid_i = 0; bus_rsp_rdata_i = 0; bus_rsp_err_i = 0;
    wb_ready_i = 0;
  endtask

  // ops = {lb, lh, lw, lbu, lhu}
  task automatic issue(input logic [31:0] addr, input logic st, input logic [4:0] ops,
                       input logic [3:0] wm, input logic [31:0] wd, input logic [4:0] rd);
    req_mem_i = 1; op_load_i = !st; op_store_i = st;
    {op_lb_i, op_lh_i, op_lw_i, op_lbu_i, op_lhu_i} = ops;
    addr_i = addr; wmask_i = wm; wdata_i = wd; rd_i = rd;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    #12;
    n_vec++;
    if ({req_ready_o, busy_o, bus_req_valid_o, bus_rsp_ready_o, wb_valid_o, exc_valid_o} !== 6'b100000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 100000",
        {req_ready_o, busy_o, bus_req_valid_o, bus_rsp_ready_o, wb_valid_o, exc_valid_o});
    end
    n_vec++;
    if ({bus_req_addr_o, bus_req_wdata_o, wb_data_o, exc_tval_o, bus_req_wmask_o, exc_cause_o,
         wb_rd_o, bus_req_we_o} !== '0) begin
      n_err++; $display("FAIL reset_data: got addr %h wdata %h wbd %h tval %h expected all 0",
        bus_req_addr_o, bus_req_wdata_o, wb_data_o, exc_tval_o);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_lb;
    issue(32'h1003, 0, 5'b10000, 4'hF, 32'h0, 5'd9);
    tick();
    clear_inputs();
    n_vec++;
    if ({bus_req_valid_o, bus_req_we_o, bus_req_wmask_o, bus_req_addr_o} !== {1'b1, 1'b0, 4'h0, 32'h1003}) begin
      n_err++; $display("FAIL lb_req: got v%b we%b m%h a%h expected v1 we0 m0 a00001003",
        bus_req_valid_o, bus_req_we_o, bus_req_wmask_o, bus_req_addr_o);
    end
    bus_req_ready_i = 1;
    tick();
    bus_req_ready_i = 0; bus_rsp_valid_i = 1; bus_rsp_rdata_i = 32'h80FF_1234;
    n_vec++;
    if ({bus_rsp_ready_o, bus_req_valid_o} !== 2'b10) begin
      n_err++; $display("FAIL lb_resp_state: got %b expected 10", {bus_rsp_ready_o, bus_req_valid_o});
    end
    tick();
    bus_rsp_valid_i = 0;
    n_vec++;
    if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd9, 32'hFFFF_FF80}) begin
      n_err++; $display("FAIL lb_wb: got v%b rd%0d d%h expected v1 rd9 dffffff80", wb_valid_o, wb_rd_o, wb_data_o);
    end
    wb_ready_i = 1;
    tick();
    wb_ready_i = 0;
    n_vec++;
    if ({wb_valid_o, req_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL lb_done: got %b expected 01", {wb_valid_o, req_ready_o});
    end
  endtask

  task automatic test_sh;
    issue(32'h2002, 1, 5'b00000, 4'b1100, 32'hBEEF_0000, 5'd0);
    tick();
    clear_inputs();
    n_vec++;
    if ({bus_req_valid_o, bus_req_we_o, bus_req_wmask_o, bus_req_addr_o, bus_req_wdata_o} !==
        {1'b1, 1'b1, 4'b1100, 32'h2002, 32'hBEEF_0000}) begin
      n_err++; $display("FAIL sh_req: got v%b we%b m%b a%h d%h expected v1 we1 m1100 a00002002 dbeef0000",
        bus_req_valid_o, bus_req_we_o, bus_req_wmask_o, bus_req_addr_o, bus_req_wdata_o);
    end
    bus_req_ready_i = 1;
    tick();
    bus_req_ready_i = 0; bus_rsp_valid_i = 1;
    tick();
    bus_rsp_valid_i = 0;
    n_vec++;
    if ({req_ready_o, wb_valid_o, busy_o, exc_valid_o} !== 4'b1000) begin
      n_err++; $display("FAIL sh_done: got %b expected 1000", {req_ready_o, wb_valid_o, busy_o, exc_valid_o});
    end
  endtask

  task automatic test_misaligned;
    issue(32'h3001, 0, 5'b00100, 4'h0, 32'h0, 5'd4);
    misaligned_load_i = 1;
    tick();
    clear_inputs();
    n_vec++;
    if ({exc_valid_o, exc_cause_o, exc_tval_o, bus_req_valid_o, req_ready_o} !==
        {1'b1, 4'd4, 32'h3001, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL mis_load: got v%b c%0d t%h bv%b rr%b expected v1 c4 t00003001 bv0 rr1",
        exc_valid_o, exc_cause_o, exc_tval_o, bus_req_valid_o, req_ready_o);
    end
    issue(32'h3006, 1, 5'b00000, 4'hF, 32'h1, 5'd0);
    misaligned_store_i = 1;
    tick();
    clear_inputs();
    n_vec++;
    if ({exc_valid_o, exc_cause_o, exc_tval_o, busy_o} !== {1'b1, 4'd6, 32'h3006, 1'b0}) begin
      n_err++; $display("FAIL mis_store: got v%b c%0d t%h busy%b expected v1 c6 t00003006 busy0",
        exc_valid_o, exc_cause_o, exc_tval_o, busy_o);
    end
    tick();
    n_vec++;
    if ({exc_valid_o, bus_req_valid_o} !== 2'b00) begin
      n_err++; $display("FAIL mis_pulse: got %b expected 00", {exc_valid_o, bus_req_valid_o});
    end
  endtask

  task automatic test_stall_err;
    issue(32'h4002, 0, 5'b00001, 4'h0, 32'h0, 5'd5);
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({bus_req_valid_o, bus_req_addr_o, bus_req_we_o} !== {1'b1, 32'h4002, 1'b0}) begin
        n_err++; $display("FAIL stall_hold%0d: got v%b a%h we%b expected v1 a00004002 we0",
          i, bus_req_valid_o, bus_req_addr_o, bus_req_we_o);
      end
      tick();
    end
    bus_req_ready_i = 1;
    tick();
    bus_req_ready_i = 0; bus_rsp_valid_i = 1; bus_rsp_err_i = 1; bus_rsp_rdata_i = 32'h1111_2222;
    tick();
    bus_rsp_valid_i = 0; bus_rsp_err_i = 0;
    n_vec++;
    if ({exc_valid_o, exc_cause_o, exc_tval_o, wb_valid_o} !== {1'b1, 4'd5, 32'h4002, 1'b0}) begin
      n_err++; $display("FAIL err_exc: got v%b c%0d t%h wb%b expected v1 c5 t00004002 wb0",
        exc_valid_o, exc_cause_o, exc_tval_o, wb_valid_o);
    end
    tick();
    n_vec++;
    if ({exc_valid_o, wb_valid_o, req_ready_o} !== 3'b001) begin
      n_err++; $display("FAIL err_after: got %b expected 001", {exc_valid_o, wb_valid_o, req_ready_o});
    end
  endtask

  task automatic test_timeout;
    int early;
    issue(32'h5000, 0, 5'b00100, 4'h0, 32'h0, 5'd3);
    tick();
    clear_inputs();
    bus_req_ready_i = 1;
    tick();
    bus_req_ready_i = 0;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      if (exc_valid_o !== 1'b0 || bus_rsp_ready_o !== 1'b1) early++;
      tick();
    end
    n_vec++;
    if (early != 0) begin
      n_err++; $display("FAIL to_wait: got %0d bad RESP cycles expected 0", early);
    end
    n_vec++;
    if ({exc_valid_o, exc_cause_o, exc_tval_o, req_ready_o, busy_o} !== {1'b1, 4'd5, 32'h5000, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL to_exc: got v%b c%0d t%h rr%b busy%b expected v1 c5 t00005000 rr0 busy1",
        exc_valid_o, exc_cause_o, exc_tval_o, req_ready_o, busy_o);
    end
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if ({req_ready_o, bus_rsp_ready_o, exc_valid_o} !== 3'b010) begin
      n_err++; $display("FAIL to_drain: got %b expected 010", {req_ready_o, bus_rsp_ready_o, exc_valid_o});
    end
    flush_i = 1;
    tick();
    flush_i = 0;
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL to_drain_flush: got busy %b expected 1", busy_o);
    end
    bus_rsp_valid_i = 1; bus_rsp_rdata_i = 32'h9999_9999;
    tick();
    bus_rsp_valid_i = 0;
    n_vec++;
    if ({req_ready_o, exc_valid_o, wb_valid_o} !== 3'b100) begin
      n_err++; $display("FAIL to_absorb: got %b expected 100", {req_ready_o, exc_valid_o, wb_valid_o});
    end
    run_load(32'h6000, 5'b00100, 5'd2, 32'h0BAD_CAFE, 32'h0BAD_CAFE, "to_next");
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [4:0] ops, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] exp, input string name);
    issue(addr, 0, ops, 4'h0, 32'h0, rd);
    tick();
    clear_inputs();
    bus_req_ready_i = 1;
    n_vec++;
    if ({bus_req_valid_o, bus_req_addr_o} !== {1'b1, addr}) begin
      n_err++; $display("FAIL %s_req: got v%b a%h expected v1 a%h", name, bus_req_valid_o, bus_req_addr_o, addr);
    end
    tick();
    bus_req_ready_i = 0; bus_rsp_valid_i = 1; bus_rsp_rdata_i = rdata;
    tick();
    bus_rsp_valid_i = 0;
    n_vec++;
    if (rd != 5'd0) begin
      if ({wb_valid_o, wb_rd_o, wb_data_o} !== {1'b1, rd, exp}) begin
        n_err++; $display("FAIL %s_wb: got v%b rd%0d d%h expected v1 rd%0d d%h",
          name, wb_valid_o, wb_rd_o, wb_data_o, rd, exp);
      end
      wb_ready_i = 1;
      tick();
      wb_ready_i = 0;
    end else begin
      if ({wb_valid_o, req_ready_o} !== 2'b01) begin
        n_err++; $display("FAIL %s_rd0: got %b expected 01", name, {wb_valid_o, req_ready_o});
      end
    end
  endtask

  task automatic test_load_format;
    run_load(32'h8002, 5'b01000, 5'd1, 32'h8001_7FFF, 32'hFFFF_8001, "lh_neg");
    run_load(32'h8000, 5'b01000, 5'd1, 32'h0000_7123, 32'h0000_7123, "lh_pos");
    run_load(32'h8000, 5'b00001, 5'd2, 32'h1234_8765, 32'h0000_8765, "lhu");
    run_load(32'h8001, 5'b00010, 5'd3, 32'h0000_A500, 32'h0000_00A5, "lbu");
    run_load(32'h8002, 5'b10000, 5'd4, 32'h0042_0000, 32'h0000_0042, "lb_pos");
    run_load(32'h8004, 5'b00100, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");
    run_load(32'h8008, 5'b00100, 5'd0, 32'h1234_5678, 32'h0, "lw_rd0");
  endtask

  task automatic test_wb_hold_flush;
    issue(32'h7000, 0, 5'b00100, 4'h0, 32'h0, 5'd7);
    tick();
    clear_inputs();
    bus_req_ready_i = 1;
    tick();
    bus_req_ready_i = 0; bus_rsp_valid_i = 1; bus_rsp_rdata_i = 32'hCAFE_F00D;
    tick();
    bus_rsp_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({wb_valid_o, wb_rd_o, wb_data_o, req_ready_o} !== {1'b1, 5'd7, 32'hCAFE_F00D, 1'b0}) begin
        n_err++; $display("FAIL wb_hold%0d: got v%b rd%0d d%h rr%b expected v1 rd7 dcafef00d rr0",
          i, wb_valid_o, wb_rd_o, wb_data_o, req_ready_o);
      end
      tick();
    end
    flush_i = 1;
    tick();
    flush_i = 0;
    n_vec++;
    if ({wb_valid_o, req_ready_o, exc_valid_o} !== 3'b010) begin
      n_err++; $display("FAIL wb_flush: got %b expected 010", {wb_valid_o, req_ready_o, exc_valid_o});
    end
  endtask

  task automatic test_flush_addr;
    issue(32'h9000, 0, 5'b00100, 4'h0, 32'h0, 5'd6);
    tick();
    clear_inputs();
    flush_i = 1;
    tick();
    flush_i = 0;
    n_vec++;
    if ({bus_req_valid_o, req_ready_o, exc_valid_o, busy_o} !== 4'b0100) begin
      n_err++; $display("FAIL flush_addr: got %b expected 0100", {bus_req_valid_o, req_ready_o, exc_valid_o, busy_o});
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_stall_err();
    test_timeout();
    test_load_format();
    test_wb_hold_flush();
    test_flush_addr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit stage directly downstream of instruction dispatch.
- Consumes the MEM-group dispatch outputs: op flags, computed address, store mask/data, misaligned flags.
- Runs one outstanding data-bus transaction on a split request/response handshake bus.
- Aligns and sign/zero-extends load data and returns it on a writeback handshake; reports misaligned, bus-error and timeout exceptions.

Parameters:
TIMEOUT_CYCLES, 255, response-wait limit in cycles; 0 disables the timeout.
RD_W, 5, destination register index width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_mem_i  in  1  MEM-group op valid from dispatch
req_ready_o  out  1  unit can accept (high only in IDLE)
op_load_i  in  1  load op
op_store_i  in  1  store op
op_lb_i, op_lh_i, op_lw_i, op_lbu_i, op_lhu_i  in  1 each  load size/sign
addr_i  in  32  effective address
wmask_i  in  4  store byte mask
wdata_i  in  32  lane-aligned store data
rd_i  in  RD_W  load destination
misaligned_load_i  in  1  load misaligned flag
misaligned_store_i  in  1  store misaligned flag
flush_i  in  1  pipeline flush
bus_req_valid_o  out  1  bus request valid
bus_req_ready_i  in  1  bus request accepted
bus_req_we_o  out  1  1 = write
bus_req_addr_o  out  32  byte address
bus_req_wmask_o  out  4  byte strobes (0 for reads)
bus_req_wdata_o  out  32  write data
bus_rsp_valid_i  in  1  response valid
bus_rsp_ready_o  out  1  response accepted
bus_rsp_rdata_i  in  32  read data
bus_rsp_err_i  in  1  access error
wb_valid_o  out  1  load result valid
wb_ready_i  in  1  writeback accepted
wb_rd_o  out  RD_W  destination
wb_data_o  out  32  extended load data
exc_valid_o  out  1  one-cycle exception pulse
exc_cause_o  out  4  4 load-misaligned, 5 load-fault, 6 store-misaligned, 7 store-fault
exc_tval_o  out  32  faulting address
busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset: state IDLE; all registers 0. After reset, every output is 0 except req_ready_o, which is 1.
- States: IDLE, ADDR, RESP, WB, DRAIN.
- IDLE: req_ready_o=1.
  - Accept when req_mem_i & !flush_i.
  - If misaligned_load_i or misaligned_store_i: no bus access. Next cycle, exc_valid_o=1 with cause 4 or 6 and tval=addr_i. Stay IDLE.
  - Otherwise latch addr, wmask, wdata, op flags and rd; go to ADDR.
- ADDR: bus_req_valid_o=1, with we/addr/wmask/wdata held stable until bus_req_ready_i.
  - On handshake: go to RESP and clear the timeout counter.
  - flush_i before handshake: go to IDLE, request withdrawn.
  - flush_i in the handshake cycle: go to DRAIN.
- RESP: bus_rsp_ready_o=1; counter increments each cycle without bus_rsp_valid_i.
  - Response with err: next cycle exc_valid_o, cause 5 (load) or 7 (store), tval = latched address; go to IDLE.
  - Response without err, store: go to IDLE.
  - Response without err, load: register formatted data; go to WB, or to IDLE if rd==0.
  - Counter reaches TIMEOUT_CYCLES (when nonzero): raise fault as for err; go to DRAIN.
  - flush_i: go to DRAIN, no exception.
  - Response and flush_i in the same cycle: response consumed and discarded, no exception; go to IDLE.
- DRAIN: bus_rsp_ready_o=1; the next response is discarded; go to IDLE. flush_i is ignored.
- WB: wb_valid_o=1 with wb_rd_o/wb_data_o stable until wb_ready_i; then IDLE. flush_i drops the result and returns to IDLE.
- Load formatting:
  - lane = addr[1:0]; byte = rdata[8*lane+7 : 8*lane]; half = addr[1] ? rdata[31:16] : rdata[15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Latency, zero-wait bus:
  - accept cycle 0; bus_req_valid cycle 1; response cycle 2; wb_valid cycle 3.
  - Store completes, req_ready_o high again, at cycle 3.
- exc_valid_o is registered, exactly one cycle wide, and never coincides with wb_valid_o.
- Only one transaction is ever outstanding; a new request is never accepted until state returns to IDLE.
- Reset mid-transaction: immediate return to IDLE, outputs at reset values. The bus must tolerate the abandoned request.

Test Plan:
- lb at 0x1003, bus rdata 0x80FF_1234 -> bus_req_addr 0x1003, we=0, wmask=0; wb_data 0xFFFF_FF80 at cycle 3.
- sh at 0x2002, wmask_i 4'b1100, wdata 0xBEEF_0000 -> bus write with mask 1100; no wb_valid; req_ready_o=1 at cycle 3.
- lw with misaligned_load_i=1, addr 0x3001 -> no bus_req_valid; exc_valid_o pulse, cause 4, tval 0x3001.
- lhu at 0x4002, bus_req_ready_i low 3 cycles, then response err=1 -> request held stable; exc cause 5, tval 0x4002; no wb.
- TIMEOUT_CYCLES=8, lw with no response -> exc cause 5 after 8 RESP cycles; late response at cycle +20 absorbed in DRAIN; next request accepted afterwards.
- lw to rd=7, wb_ready_i low 4 cycles -> wb_valid/wb_data held; flush_i in WB -> wb_valid drops, req_ready_o=1 next cycle.
